// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: accepts an op over valid/ready, walks the operands LSB first
// through 1-bit gate logic with a carry flop, and presents the assembled result with flags.
module serial_alu_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero,
   output logic             err
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [2:0] OP_NAND = 3'b000;
   localparam logic [2:0] OP_OR   = 3'b001;
   localparam logic [2:0] OP_NOT  = 3'b010;
   localparam logic [2:0] OP_EXOR = 3'b011;
   localparam logic [2:0] OP_ADD  = 3'b100;
   localparam logic [2:0] OP_SUB  = 3'b101;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_RUN  = 2'b01,
      S_DONE = 2'b10
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_sh;
   logic [WIDTH-1:0] r_result;
   logic [2:0]       r_op;
   logic [CW-1:0]    r_cnt;
   logic             r_c;
   logic             r_carry;
   logic             r_zero;
   logic             r_err;

   logic             w_accept;
   logic             w_last;
   logic             w_ai;
   logic             w_bi;
   logic             w_bx;
   logic             w_bit;
   logic             w_c_nxt;
   logic             w_arith;
   logic             w_rsv;
   logic [WIDTH-1:0] w_sh_nxt;

   assign in_ready  = (r_state == S_IDLE) && !rst;
   assign out_valid = (r_state == S_DONE);
   assign w_accept  = in_valid && in_ready;
   assign w_last    = (r_cnt == CNT_LAST);
   assign w_arith   = (r_op == OP_ADD) || (r_op == OP_SUB);
   assign w_rsv     = r_op[2] & r_op[1];
   assign result    = r_result;
   assign carry     = r_carry;
   assign zero      = r_zero;
   assign err       = r_err;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: if (w_accept) w_state_nxt = S_RUN;  else w_state_nxt = S_IDLE;
         S_RUN:  if (w_last)   w_state_nxt = S_DONE; else w_state_nxt = S_RUN;
         S_DONE: if (out_ready) w_state_nxt = S_IDLE; else w_state_nxt = S_DONE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // One gate-level bit per cycle; SUB is ADD of the inverted operand with carry preset to 1
   always_comb begin
      w_ai    = r_a[r_cnt];
      w_bi    = r_b[r_cnt];
      w_bx    = (r_op == OP_SUB) ? ~w_bi : w_bi;
      w_c_nxt = (w_ai & w_bx) | (r_c & (w_ai ^ w_bx));
      case (r_op)
         OP_NAND: w_bit = ~(w_ai & w_bi);
         OP_OR:   w_bit = w_ai | w_bi;
         OP_NOT:  w_bit = ~w_ai;
         OP_EXOR: w_bit = w_ai ^ w_bi;
         OP_ADD,
         OP_SUB:  w_bit = w_ai ^ w_bx ^ r_c;
         default: w_bit = 1'b0;
      endcase
      w_sh_nxt = {w_bit, r_sh[WIDTH-1:1]};
   end

   // Operand capture, serial datapath and registered result/flags
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_a      <= '0;
         r_b      <= '0;
         r_op     <= 3'b000;
         r_cnt    <= '0;
         r_c      <= 1'b0;
         r_sh     <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
         r_err    <= 1'b0;
      end else if (w_accept) begin
         r_a      <= a;
         r_b      <= b;
         r_op     <= op;
         r_cnt    <= '0;
         r_c      <= (op == OP_SUB);
         r_sh     <= '0;
         r_result <= '0;
         r_carry  <= 1'b0;
         r_zero   <= 1'b0;
         r_err    <= 1'b0;
      end else if (r_state == S_RUN) begin
         r_c  <= w_c_nxt;
         r_sh <= w_sh_nxt;
         if (w_last) begin
            r_result <= w_sh_nxt;
            r_carry  <= w_arith & w_c_nxt;
            r_zero   <= ~|w_sh_nxt;
            r_err    <= w_rsv;
         end else begin
            r_cnt <= r_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_serial_alu_ctrl.sv
// Directed self-checking bench for serial_alu_ctrl at WIDTH=8.
module tb_serial_alu_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [2:0] op = 3'b000;
   logic [7:0] a = 8'h00;
   logic [7:0] b = 8'h00;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] result;
   logic       carry;
   logic       zero;
   logic       err;

   int n_vec  = 0;
   int n_miss = 0;

   serial_alu_ctrl #(.WIDTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
      .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .carry(carry), .zero(zero), .err(err)
   );

   always #5 clk = ~clk;

   // Presents one op, scrambles operands after accept, counts edges until out_valid (bounded)
   task automatic apply(input logic [2:0] t_op, input logic [7:0] t_a, input logic [7:0] t_b,
                        output int lat);
      op = t_op; a = t_a; b = t_b; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      a = 8'($urandom); b = 8'($urandom); op = 3'($urandom);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_out();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      n_vec++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin n_miss++;
         $display("FAIL reset_hs got in_ready=%b out_valid=%b exp 0 0", in_ready, out_valid); end
      n_vec++; if ({result, carry, zero, err} !== 11'd0) begin n_miss++;
         $display("FAIL reset_out got r=%h c=%b z=%b e=%b exp all 0", result, carry, zero, err); end
      @(negedge clk); rst = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (in_ready !== 1'b1) begin n_miss++;
         $display("FAIL reset_release got in_ready=%b exp 1", in_ready); end
   endtask

   task automatic test_add();
      int lat;
      apply(3'b100, 8'hFF, 8'h01, lat);
      n_vec++; if (lat !== 8) begin n_miss++;
         $display("FAIL add_latency got %0d exp 8", lat); end
      n_vec++; if ({result, carry, zero, err} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin n_miss++;
         $display("FAIL add_ff01 got r=%h c=%b z=%b e=%b exp 00 1 1 0", result, carry, zero, err); end
      n_vec++; if (in_ready !== 1'b0) begin n_miss++;
         $display("FAIL add_done_ready got %b exp 0", in_ready); end
      release_out();
      n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_miss++;
         $display("FAIL add_release got ov=%b ir=%b exp 0 1", out_valid, in_ready); end
   endtask

   task automatic test_sub();
      int lat;
      apply(3'b101, 8'h05, 8'h07, lat);
      n_vec++; if ({result, carry, zero} !== {8'hFE, 1'b0, 1'b0} || lat !== 8) begin n_miss++;
         $display("FAIL sub_05_07 got r=%h c=%b z=%b lat=%0d exp FE 0 0 8", result, carry, zero, lat); end
      release_out();
      apply(3'b101, 8'h07, 8'h05, lat);
      n_vec++; if ({result, carry, zero} !== {8'h02, 1'b1, 1'b0} || lat !== 8) begin n_miss++;
         $display("FAIL sub_07_05 got r=%h c=%b z=%b lat=%0d exp 02 1 0 8", result, carry, zero, lat); end
      release_out();
      apply(3'b101, 8'h33, 8'h33, lat);
      n_vec++; if ({result, carry, zero} !== {8'h00, 1'b1, 1'b1}) begin n_miss++;
         $display("FAIL sub_equal got r=%h c=%b z=%b exp 00 1 1", result, carry, zero); end
      release_out();
   endtask

   task automatic test_logic();
      int lat;
      logic [2:0] t_op;
      logic [7:0] t_a, t_b, t_exp;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: begin t_op = 3'b000; t_a = 8'hF0; t_b = 8'hCC; t_exp = 8'h3F; end
            1: begin t_op = 3'b001; t_a = 8'hF0; t_b = 8'hCC; t_exp = 8'hFC; end
            2: begin t_op = 3'b011; t_a = 8'hF0; t_b = 8'hCC; t_exp = 8'h3C; end
            default: begin t_op = 3'b010; t_a = 8'hA5; t_b = 8'hFF; t_exp = 8'h5A; end
         endcase
         apply(t_op, t_a, t_b, lat);
         n_vec++; if ({result, carry, zero, err} !== {t_exp, 3'b000} || lat !== 8) begin n_miss++;
            $display("FAIL logic_op%0d got r=%h c=%b z=%b e=%b lat=%0d exp %h 0 0 0 8",
                     t_op, result, carry, zero, err, lat, t_exp); end
         release_out();
      end
   endtask

   task automatic test_back_to_back();
      int lat;
      int bad;
      apply(3'b100, 8'h01, 8'h02, lat);
      op = 3'b100; a = 8'h10; b = 8'h20; in_valid = 1'b1;
      bad = 0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || result !== 8'h03) bad++;
      end
      n_vec++; if (bad !== 0) begin n_miss++;
         $display("FAIL backpressure_hold got %0d bad cycles exp 0 (r=%h ov=%b ir=%b)",
                  bad, result, out_valid, in_ready); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_vec++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_miss++;
         $display("FAIL backpressure_ready got ir=%b ov=%b exp 1 0", in_ready, out_valid); end
      apply(3'b100, 8'h10, 8'h20, lat);
      n_vec++; if (result !== 8'h30 || lat !== 8) begin n_miss++;
         $display("FAIL backpressure_next got r=%h lat=%0d exp 30 8", result, lat); end
      release_out();
   endtask

   task automatic test_reset_mid();
      int lat;
      int bad;
      op = 3'b100; a = 8'hFF; b = 8'hFF; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #3; rst = 1'b1;
      #1;
      n_vec++; if (out_valid !== 1'b0 || in_ready !== 1'b0 || result !== 8'h00) begin n_miss++;
         $display("FAIL midreset_assert got ov=%b ir=%b r=%h exp 0 0 00", out_valid, in_ready, result); end
      #1; rst = 1'b0;
      #1;
      n_vec++; if (in_ready !== 1'b1) begin n_miss++;
         $display("FAIL midreset_release got ir=%b exp 1", in_ready); end
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (out_valid !== 1'b0) bad++;
      end
      n_vec++; if (bad !== 0) begin n_miss++;
         $display("FAIL midreset_no_output got %0d valid cycles exp 0", bad); end
      apply(3'b100, 8'h12, 8'h34, lat);
      n_vec++; if ({result, carry, zero} !== {8'h46, 1'b0, 1'b0} || lat !== 8) begin n_miss++;
         $display("FAIL midreset_add got r=%h c=%b z=%b lat=%0d exp 46 0 0 8", result, carry, zero, lat); end
      release_out();
   endtask

   task automatic test_reserved();
      int lat;
      apply(3'b111, 8'hFF, 8'h0F, lat);
      n_vec++; if ({result, carry, zero, err} !== {8'h00, 1'b0, 1'b1, 1'b1} || lat !== 8) begin n_miss++;
         $display("FAIL reserved_111 got r=%h c=%b z=%b e=%b lat=%0d exp 00 0 1 1 8",
                  result, carry, zero, err, lat); end
      release_out();
      apply(3'b110, 8'h5A, 8'hA5, lat);
      n_vec++; if ({result, zero, err} !== {8'h00, 1'b1, 1'b1}) begin n_miss++;
         $display("FAIL reserved_110 got r=%h z=%b e=%b exp 00 1 1", result, zero, err); end
      release_out();
      apply(3'b100, 8'h01, 8'h01, lat);
      n_vec++; if ({result, carry, zero, err} !== {8'h02, 3'b000}) begin n_miss++;
         $display("FAIL reserved_clear got r=%h c=%b z=%b e=%b exp 02 0 0 0", result, carry, zero, err); end
      release_out();
   endtask

   initial begin
      test_reset();
      test_add();
      test_sub();
      test_logic();
      test_back_to_back();
      test_reset_mid();
      test_reserved();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
